mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single backing-memory port between the instruction-cache and
//  data-cache controllers (each a cache FSM issuing line fill / write-back
//  requests). Round-robin arbitration, one outstanding transaction at a time,
//  ownership locked until memory responds. A watchdog aborts hung transactions.
//  Sits between the two cache controllers and the memory model/controller.
// PARAMETERS
//  ADDR_W       16   request address width (word address from the CPU side)
//  LINE_W       64   cache-line width carried on mem req/rsp data
//  TIMEOUT_CYC  256  max cycles in a grant state before abort (>=2)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       reset; asynchronous, active-high
//  i_req_valid    in   1       I-cache request; held until i_rsp_ready seen
//  i_req_rw       in   1       1=write-back, 0=line fill
//  i_req_addr     in   ADDR_W  I-cache request address
//  i_req_data     in   LINE_W  I-cache write-back line
//  i_rsp_ready    out  1       1-cycle completion pulse to I-cache
//  d_req_valid/d_req_rw/d_req_addr/d_req_data  in  as I-side, for D-cache
//  d_rsp_ready    out  1       1-cycle completion pulse to D-cache
//  rsp_data       out  LINE_W  fill data; valid with the owner's rsp_ready
//  rsp_err        out  1       qualifies rsp_ready: 1 = aborted by timeout
//  mem_req_valid  out  1       request to memory; high for the whole grant
//  mem_req_rw     out  1       captured rw
//  mem_req_addr   out  ADDR_W  captured address
//  mem_req_data   out  LINE_W  captured write data
//  mem_rsp_ready  in   1       memory completion pulse
//  mem_rsp_data   in   LINE_W  memory read data
//  busy           out  1       state != IDLE
// BEHAVIOUR
//  - States: IDLE, GRANT_I, GRANT_D. Reset: IDLE, rr_last=D (I wins first tie),
//    all outputs 0, watchdog 0, capture regs 0.
//  - IDLE: only I valid -> GRANT_I; only D valid -> GRANT_D; both -> side !=
//    rr_last. On grant edge: capture rw/addr/data of winner, rr_last<=winner,
//    wd<=0. Arbitration decision is combinational in IDLE, registered at edge.
//  - GRANT_x: mem_req_valid=1, mem_req_* from capture regs (stable whole grant;
//    requester input changes ignored). Latency: grant edge +1 cycle min.
//  - mem_rsp_ready in GRANT_x: x_rsp_ready=1 same cycle (combinational),
//    rsp_data=mem_rsp_data, rsp_err=0; next state IDLE. Non-owner rsp_ready=0.
//  - Always one IDLE bubble between transactions (requester drops valid the
//    cycle after rsp_ready; valid still high in IDLE is a new request).
//  - Watchdog: wd increments each GRANT cycle without mem_rsp_ready; when
//    wd==TIMEOUT_CYC-1 and no ready: owner rsp_ready=1, rsp_err=1, rsp_data=0,
//    next IDLE. Ready and timeout same cycle -> normal completion (err=0).
//  - mem_rsp_ready while IDLE: ignored, no outputs pulse.
//  - rsp_data = 0 whenever no rsp_ready is asserted.
//  - rst asserted mid-grant: immediate return to IDLE, outputs 0; in-flight
//    memory transaction is abandoned (memory is reset by the same rst).
//  - mem_req_valid deasserts in the cycle after mem_rsp_ready (state IDLE).
// STRUCTURE
//  - Shared package (alongside icache_def): arb_state_t enum, arb_owner_t
//    {OWN_I,OWN_D}, arb_req_t {valid,rw,addr,data} struct, TIMEOUT_CYC default.
//  - One sub-module: arb_watchdog (counter, clear, enable, expire output).
//  - Main module: state/owner/capture regs + combinational response routing.
// TESTING
//  1 I req addr=16'h0040 rw=0; mem ready 3 cyc after grant, data=64'hA5A5_0000_1234_5678
//    -> mem_req_valid 1 cycle after req, i_rsp_ready 1 cyc with that data, d_rsp_ready 0.
//  2 I and D valid same cycle after reset -> I granted first; after done, D
//    granted after one IDLE bubble; next tie -> I (alternation holds 4 rounds).
//  3 D write-back rw=1 addr=16'h1F00 data=64'hDEAD_BEEF_0000_0001, D changes addr
//    mid-grant -> mem_req_addr/data stay 16'h1F00/captured value until ready.
//  4 memory never responds, TIMEOUT_CYC=8 -> owner rsp_ready+rsp_err exactly
//    8 cycles into grant, rsp_data=0, busy drops next cycle.
//  5 mem_rsp_ready on timeout cycle -> rsp_err=0, data delivered; stray ready in IDLE -> no pulse.
//  6 rst pulse 2 cycles into a grant -> outputs 0 asynchronously; new D req after
//    release granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-cache memory-port arbiter.
// The request struct uses the default widths and is meant for the cache controllers.
package mem_port_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W      = 16;
  localparam int unsigned ARB_LINE_W      = 64;
  localparam int unsigned ARB_TIMEOUT_CYC = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic                  valid;
    logic                  rw;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_LINE_W-1:0] data;
  } arb_req_t;

  // On a tie the side that did not win last time gets the port.
  function automatic arb_owner_t arb_pick(input logic i_valid,
                                          input logic d_valid,
                                          input arb_owner_t rr_last);
    arb_owner_t pick;
    if (i_valid && d_valid) begin
      if (rr_last == OWN_D) pick = OWN_I;
      else                  pick = OWN_D;
    end else if (d_valid) begin
      pick = OWN_D;
    end else begin
      pick = OWN_I;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals around the arbiter.
// master = arbiter view, slave = the surrounding caches and memory.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned LINE_W = ARB_LINE_W
);

  logic              i_req_valid;
  logic              i_req_rw;
  logic [ADDR_W-1:0] i_req_addr;
  logic [LINE_W-1:0] i_req_data;
  logic              i_rsp_ready;

  logic              d_req_valid;
  logic              d_req_rw;
  logic [ADDR_W-1:0] d_req_addr;
  logic [LINE_W-1:0] d_req_data;
  logic              d_rsp_ready;

  logic [LINE_W-1:0] rsp_data;
  logic              rsp_err;

  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_data;
  logic              mem_rsp_ready;
  logic [LINE_W-1:0] mem_rsp_data;

  logic              busy;

  modport master (
    input  i_req_valid, i_req_rw, i_req_addr, i_req_data,
    input  d_req_valid, d_req_rw, d_req_addr, d_req_data,
    input  mem_rsp_ready, mem_rsp_data,
    output i_rsp_ready, d_rsp_ready, rsp_data, rsp_err,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
    output busy
  );

  modport slave (
    output i_req_valid, i_req_rw, i_req_addr, i_req_data,
    output d_req_valid, d_req_rw, d_req_addr, d_req_data,
    output mem_rsp_ready, mem_rsp_data,
    input  i_rsp_ready, d_rsp_ready, rsp_data, rsp_err,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
    input  busy
  );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Grant-cycle counter; expire flags the last cycle a grant may wait for memory.
module mem_port_arbiter_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned       CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else if (clear) begin
      wd_q <= '0;
    end else if (enable) begin
      wd_q <= wd_q + CNT_W'(1);
    end
  end

  assign expire = (wd_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single memory port shared by the I- and D-cache.
// One transaction at a time; the owner is locked until memory answers or the watchdog fires.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = ARB_ADDR_W,
  parameter int unsigned LINE_W      = ARB_LINE_W,
  parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.master bus
);

  arb_state_t        state_q, state_d;
  arb_owner_t        rr_last_q;
  arb_owner_t        winner;
  logic              cap_rw_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [LINE_W-1:0] cap_data_q;
  logic              in_grant;
  logic              grant_edge;
  logic              wd_expire;

  assign in_grant   = (state_q != IDLE);
  assign grant_edge = (state_q == IDLE) && (state_d != IDLE);
  assign winner     = arb_pick(bus.i_req_valid, bus.d_req_valid, rr_last_q);

  mem_port_arbiter_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_grant),
    .enable (in_grant && !bus.mem_rsp_ready),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The winner's request is frozen here so later requester changes cannot leak to memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q  <= OWN_D;
      cap_rw_q   <= 1'b0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
    end else if (grant_edge) begin
      rr_last_q <= winner;
      if (winner == OWN_I) begin
        cap_rw_q   <= bus.i_req_rw;
        cap_addr_q <= bus.i_req_addr;
        cap_data_q <= bus.i_req_data;
      end else begin
        cap_rw_q   <= bus.d_req_rw;
        cap_addr_q <= bus.d_req_addr;
        cap_data_q <= bus.d_req_data;
      end
    end
  end

  // A real memory response beats a watchdog expiry in the same cycle.
  always_comb begin
    state_d           = state_q;
    bus.i_rsp_ready   = 1'b0;
    bus.d_rsp_ready   = 1'b0;
    bus.rsp_data      = '0;
    bus.rsp_err       = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_rw    = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_data  = '0;
    bus.busy          = in_grant;
    unique case (state_q)
      IDLE: begin
        if (bus.i_req_valid || bus.d_req_valid) begin
          state_d = (winner == OWN_I) ? GRANT_I : GRANT_D;
        end
      end
      GRANT_I, GRANT_D: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = cap_rw_q;
        bus.mem_req_addr  = cap_addr_q;
        bus.mem_req_data  = cap_data_q;
        if (bus.mem_rsp_ready || wd_expire) begin
          state_d = IDLE;
          if (state_q == GRANT_I) bus.i_rsp_ready = 1'b1;
          else                    bus.d_rsp_ready = 1'b1;
          if (bus.mem_rsp_ready) bus.rsp_data = bus.mem_rsp_data;
          else                   bus.rsp_err  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 8;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.ADDR_W(16), .LINE_W(64)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (16),
    .LINE_W      (64),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] global timeout");
  end

  // Model: who owns the port (0 none, 1 I, 2 D), how long, and what was captured.
  int          m_owner = 0;
  int          m_last  = 2;
  int          m_age   = 0;
  logic        m_rw    = 1'b0;
  logic [15:0] m_addr  = '0;
  logic [63:0] m_data  = '0;

  logic        e_irdy = 1'b0;
  logic        e_drdy = 1'b0;
  logic        e_err  = 1'b0;
  logic        e_mv   = 1'b0;
  logic        e_busy = 1'b0;
  logic [63:0] e_data = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic irw, input logic [15:0] iaddr,
                               input logic [63:0] idata, input logic dv, input logic drw,
                               input logic [15:0] daddr, input logic [63:0] ddata,
                               input logic mrdy, input logic [63:0] mdata);
    bus.i_req_valid   = iv;
    bus.i_req_rw      = irw;
    bus.i_req_addr    = iaddr;
    bus.i_req_data    = idata;
    bus.d_req_valid   = dv;
    bus.d_req_rw      = drw;
    bus.d_req_addr    = daddr;
    bus.d_req_data    = ddata;
    bus.mem_rsp_ready = mrdy;
    bus.mem_rsp_data  = mdata;
  endtask

  task automatic waitGrant();
    bit found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (bus.mem_req_valid === 1'b1) found = 1;
      else tick();
    end
    checkOutput("grant_seen", 64'(found), 64'd1);
  endtask

  // Per-cycle reference: outputs follow from ownership, age and the current inputs.
  initial begin
    int win;
    forever begin
      @(negedge clk);
      e_irdy = 1'b0; e_drdy = 1'b0; e_err = 1'b0; e_mv = 1'b0; e_data = '0;
      if (rst) begin
        e_busy  = 1'b0;
        m_owner = 0; m_last = 2; m_age = 0;
        m_rw = 1'b0; m_addr = '0; m_data = '0;
      end else begin
        e_busy = (m_owner != 0);
        if (m_owner == 0) begin
          win = 0;
          if (bus.i_req_valid && bus.d_req_valid) win = 3 - m_last;
          else if (bus.i_req_valid) win = 1;
          else if (bus.d_req_valid) win = 2;
          if (win != 0) begin
            m_owner = win; m_last = win; m_age = 0;
            m_rw    = (win == 1) ? bus.i_req_rw   : bus.d_req_rw;
            m_addr  = (win == 1) ? bus.i_req_addr : bus.d_req_addr;
            m_data  = (win == 1) ? bus.i_req_data : bus.d_req_data;
          end
        end else begin
          e_mv = 1'b1;
          if (bus.mem_rsp_ready || m_age == TIMEOUT - 1) begin
            e_irdy = (m_owner == 1);
            e_drdy = (m_owner == 2);
            if (bus.mem_rsp_ready) e_data = bus.mem_rsp_data;
            else e_err = 1'b1;
          end
        end
      end
      checkOutput("m_i_rsp_ready",   64'(bus.i_rsp_ready),   64'(e_irdy));
      checkOutput("m_d_rsp_ready",   64'(bus.d_rsp_ready),   64'(e_drdy));
      checkOutput("m_rsp_err",       64'(bus.rsp_err),       64'(e_err));
      checkOutput("m_rsp_data",      bus.rsp_data,           e_data);
      checkOutput("m_mem_req_valid", 64'(bus.mem_req_valid), 64'(e_mv));
      checkOutput("m_busy",          64'(bus.busy),          64'(e_busy));
      if (e_mv) begin
        checkOutput("m_mem_req_rw",   64'(bus.mem_req_rw),   64'(m_rw));
        checkOutput("m_mem_req_addr", 64'(bus.mem_req_addr), 64'(m_addr));
        checkOutput("m_mem_req_data", bus.mem_req_data,      m_data);
      end
      if (!rst && m_owner != 0 && e_mv) begin
        if (e_irdy || e_drdy) m_owner = 0;
        else m_age++;
      end
    end
  end

  task automatic runRandom(input int cycles, input int rdy_pct);
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (bus.i_req_valid && e_irdy) begin
        bus.i_req_valid = 1'b0;
      end else if (bus.i_req_valid) begin
        if ($urandom_range(0, 7) == 0) bus.i_req_addr = 16'($urandom);
      end else if ($urandom_range(0, 2) == 0) begin
        bus.i_req_valid = 1'b1;
        bus.i_req_rw    = 1'($urandom);
        bus.i_req_addr  = 16'($urandom);
        bus.i_req_data  = {$urandom, $urandom};
      end
      if (bus.d_req_valid && e_drdy) begin
        bus.d_req_valid = 1'b0;
      end else if (bus.d_req_valid) begin
        if ($urandom_range(0, 7) == 0) bus.d_req_data = {$urandom, $urandom};
      end else if ($urandom_range(0, 2) == 0) begin
        bus.d_req_valid = 1'b1;
        bus.d_req_rw    = 1'($urandom);
        bus.d_req_addr  = 16'($urandom);
        bus.d_req_data  = {$urandom, $urandom};
      end
      bus.mem_rsp_ready = ($urandom_range(0, 99) < rdy_pct);
      bus.mem_rsp_data  = {$urandom, $urandom};
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 0, 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy",          64'(bus.busy),          64'd0);
    checkOutput("reset_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    checkOutput("reset_i_rsp_ready",   64'(bus.i_rsp_ready),   64'd0);
    checkOutput("reset_d_rsp_ready",   64'(bus.d_rsp_ready),   64'd0);
    tick();
    rst = 1'b0;

    // Single I-cache line fill, memory answers three cycles into the grant.
    applyStimulus(1, 0, 16'h0040, 64'h0, 0, 0, 16'h0, 64'h0, 0, 64'h0);
    @(negedge clk);
    checkOutput("t1_no_req_same_cycle", 64'(bus.mem_req_valid), 64'd0);
    tick();
    @(negedge clk);
    checkOutput("t1_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
    checkOutput("t1_mem_req_addr",  64'(bus.mem_req_addr),  64'h0040);
    checkOutput("t1_mem_req_rw",    64'(bus.mem_req_rw),    64'd0);
    tick();
    tick();
    tick();
    bus.mem_rsp_ready = 1'b1;
    bus.mem_rsp_data  = 64'hA5A5_0000_1234_5678;
    @(negedge clk);
    checkOutput("t1_i_rsp_ready", 64'(bus.i_rsp_ready), 64'd1);
    checkOutput("t1_rsp_data",    bus.rsp_data,         64'hA5A5_0000_1234_5678);
    checkOutput("t1_d_rsp_ready", 64'(bus.d_rsp_ready), 64'd0);
    checkOutput("t1_rsp_err",     64'(bus.rsp_err),     64'd0);
    tick();
    applyStimulus(0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 0, 64'h0);
    @(negedge clk);
    checkOutput("t1_busy_after",  64'(bus.busy),          64'd0);
    checkOutput("t1_valid_after", 64'(bus.mem_req_valid), 64'd0);

    // Fresh reset, then both caches keep requesting: strict I/D alternation.
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    applyStimulus(1, 0, 16'h0100, 64'h11, 1, 0, 16'h0200, 64'h22, 0, 64'h0);
    for (int g = 0; g < 8; g++) begin
      waitGrant();
      checkOutput("t2_owner_addr", 64'(bus.mem_req_addr),
                  (g % 2 == 0) ? 64'h0100 : 64'h0200);
      tick();
      bus.mem_rsp_ready = 1'b1;
      bus.mem_rsp_data  = 64'h100 + 64'(g);
      @(negedge clk);
      checkOutput("t2_i_rsp_ready", 64'(bus.i_rsp_ready), (g % 2 == 0) ? 64'd1 : 64'd0);
      checkOutput("t2_d_rsp_ready", 64'(bus.d_rsp_ready), (g % 2 == 0) ? 64'd0 : 64'd1);
      tick();
      bus.mem_rsp_ready = 1'b0;
      if (g % 2 == 0) bus.i_req_valid = 1'b0;
      else bus.d_req_valid = 1'b0;
      tick();
      if (g < 6) begin
        if (g % 2 == 0) bus.i_req_valid = 1'b1;
        else bus.d_req_valid = 1'b1;
      end
    end

    // D write-back; requester changes its inputs mid-grant.
    applyStimulus(0, 0, 16'h0, 64'h0, 1, 1, 16'h1F00, 64'hDEAD_BEEF_0000_0001, 0, 64'h0);
    tick();
    @(negedge clk);
    checkOutput("t3_addr", 64'(bus.mem_req_addr), 64'h1F00);
    checkOutput("t3_data", bus.mem_req_data,      64'hDEAD_BEEF_0000_0001);
    checkOutput("t3_rw",   64'(bus.mem_req_rw),   64'd1);
    tick();
    bus.d_req_addr = 16'h2222;
    bus.d_req_data = 64'h5555_5555_5555_5555;
    bus.d_req_rw   = 1'b0;
    @(negedge clk);
    checkOutput("t3_addr_held", 64'(bus.mem_req_addr), 64'h1F00);
    checkOutput("t3_data_held", bus.mem_req_data,      64'hDEAD_BEEF_0000_0001);
    checkOutput("t3_rw_held",   64'(bus.mem_req_rw),   64'd1);
    tick();
    bus.mem_rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("t3_d_rsp_ready", 64'(bus.d_rsp_ready), 64'd1);
    checkOutput("t3_i_rsp_ready", 64'(bus.i_rsp_ready), 64'd0);
    tick();
    applyStimulus(0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 0, 64'h0);

    // Memory never answers: abort lands on the eighth grant cycle.
    tick();
    applyStimulus(1, 0, 16'h0ABC, 64'h0, 0, 0, 16'h0, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      @(negedge clk);
      checkOutput("t4_no_early_abort", 64'(bus.i_rsp_ready), 64'd0);
      tick();
    end
    @(negedge clk);
    checkOutput("t4_i_rsp_ready", 64'(bus.i_rsp_ready), 64'd1);
    checkOutput("t4_rsp_err",     64'(bus.rsp_err),     64'd1);
    checkOutput("t4_rsp_data",    bus.rsp_data,         64'd0);
    checkOutput("t4_d_rsp_ready", 64'(bus.d_rsp_ready), 64'd0);
    tick();
    applyStimulus(0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 0, 64'h0);
    @(negedge clk);
    checkOutput("t4_busy_drops", 64'(bus.busy), 64'd0);

    // Memory answers exactly on the timeout cycle, then a stray ready in IDLE.
    tick();
    applyStimulus(0, 0, 16'h0, 64'h0, 1, 0, 16'h0D00, 64'h0, 0, 64'h0);
    tick();
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      @(negedge clk);
      tick();
    end
    bus.mem_rsp_ready = 1'b1;
    bus.mem_rsp_data  = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    checkOutput("t5_d_rsp_ready", 64'(bus.d_rsp_ready), 64'd1);
    checkOutput("t5_rsp_err",     64'(bus.rsp_err),     64'd0);
    checkOutput("t5_rsp_data",    bus.rsp_data,         64'h0123_4567_89AB_CDEF);
    tick();
    applyStimulus(0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 1, 64'hCAFE_F00D_CAFE_F00D);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("t5_stray_i", 64'(bus.i_rsp_ready), 64'd0);
      checkOutput("t5_stray_d", 64'(bus.d_rsp_ready), 64'd0);
      checkOutput("t5_stray_data", bus.rsp_data, 64'd0);
      tick();
    end
    applyStimulus(0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 0, 64'h0);

    // Reset lands two cycles into a grant, then a new D request runs normally.
    tick();
    applyStimulus(0, 0, 16'h0, 64'h0, 1, 0, 16'h0333, 64'h33, 0, 64'h0);
    tick();
    tick();
    tick();
    checkOutput("t6_busy_before_rst", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6_async_valid", 64'(bus.mem_req_valid), 64'd0);
    checkOutput("t6_async_busy",  64'(bus.busy),          64'd0);
    checkOutput("t6_async_addr",  64'(bus.mem_req_addr),  64'd0);
    applyStimulus(0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 0, 64'h0);
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 16'h0, 64'h0, 1, 0, 16'h0777, 64'h77, 0, 64'h0);
    tick();
    @(negedge clk);
    checkOutput("t6_regrant_valid", 64'(bus.mem_req_valid), 64'd1);
    checkOutput("t6_regrant_addr",  64'(bus.mem_req_addr),  64'h0777);
    tick();
    bus.mem_rsp_ready = 1'b1;
    bus.mem_rsp_data  = 64'h7777_0000_7777_0000;
    @(negedge clk);
    checkOutput("t6_d_rsp_ready", 64'(bus.d_rsp_ready), 64'd1);
    checkOutput("t6_rsp_data",    bus.rsp_data,         64'h7777_0000_7777_0000);
    tick();
    applyStimulus(0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 0, 64'h0);

    // Random traffic: busy memory first, then a sluggish one that trips the watchdog.
    runRandom(1500, 30);
    runRandom(600, 4);
    tick();
    applyStimulus(0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 0, 64'h0);
    repeat (TIMEOUT + 4) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
